// File: rtl/quant_zigzag.sv
// Quantizer and zigzag reorder stage for one 8x8 DCT block.
// Latches a block in parallel, then streams 64 quantized coefficients in zigzag order.
module quant_zigzag #(
  parameter int unsigned CW = 8,
  parameter int unsigned RW = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             blk_valid,
  output logic             blk_ready,
  input  logic [64*CW-1:0] coef_in,
  input  logic             qt_wr_en,
  input  logic [5:0]       qt_wr_addr,
  input  logic [RW-1:0]    qt_wr_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_coef,
  output logic [5:0]       out_index,
  output logic             out_last
);

  localparam int unsigned PW = CW + RW + 1;
  localparam int unsigned Shift = 16;
  localparam logic [PW-1:0] MaxPos = PW'((1 << (CW - 1)) - 1);
  localparam logic [PW-1:0] MaxNeg = PW'(1 << (CW - 1));

  localparam logic [5:0] ZigZag [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10, 6'd17, 6'd24, 6'd32, 6'd25, 6'd18,
    6'd11, 6'd4,  6'd5,  6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34, 6'd27, 6'd20,
    6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28, 6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43,
    6'd36, 6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51, 6'd58, 6'd59, 6'd52, 6'd45,
    6'd38, 6'd31, 6'd39, 6'd46, 6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  typedef enum logic {StIdle, StRun} state_e;

  state_e        state_q, state_d;
  logic [6:0]    rd_q, rd_d;
  logic          ov_q, ov_d;
  logic [CW-1:0] oc_q, oc_d;
  logic [5:0]    oi_q, oi_d;
  logic          ol_q, ol_d;
  logic          accept;

  logic [CW-1:0] blk_q [64];
  logic [RW-1:0] qt_q [64];

  logic [5:0]           nat;
  logic signed [CW-1:0] qx;
  logic [RW-1:0]        qr;
  logic signed [PW-1:0] prod;
  logic [PW-1:0]        mag_p;
  logic [PW-1:0]        mag;
  logic [CW-1:0]        qres;

  assign blk_ready = (state_q == StIdle);
  assign accept    = blk_valid && blk_ready;
  assign out_valid = ov_q;
  assign out_coef  = oc_q;
  assign out_index = oi_q;
  assign out_last  = ol_q;

  // Round half away from zero on the magnitude, then restore the sign and saturate.
  always_comb begin
    nat   = ZigZag[rd_q[5:0]];
    qx    = $signed(blk_q[nat]);
    qr    = qt_q[nat];
    prod  = PW'(qx) * PW'($signed({1'b0, qr}));
    mag_p = prod[PW-1] ? $unsigned(-prod) : $unsigned(prod);
    mag   = (mag_p + (PW'(1) << (Shift - 1))) >> Shift;
    if (qr == '0) begin
      qres = qx;
    end else if (qx[CW-1]) begin
      qres = (mag > MaxNeg) ? {1'b1, {(CW-1){1'b0}}} : -mag[CW-1:0];
    end else begin
      qres = (mag > MaxPos) ? {1'b0, {(CW-1){1'b1}}} : mag[CW-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    ov_d    = ov_q;
    oc_d    = oc_q;
    oi_d    = oi_q;
    ol_d    = ol_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StRun;
          rd_d    = '0;
        end
      end
      StRun: begin
        if (!ov_q || out_ready) begin
          if (rd_q <= 7'd63) begin
            oc_d = qres;
            oi_d = rd_q[5:0];
            ol_d = (rd_q == 7'd63);
            ov_d = 1'b1;
            rd_d = rd_q + 7'd1;
          end else begin
            // rd past the end: the pending beat is the last one and was just taken
            ov_d    = 1'b0;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      rd_q    <= '0;
      ov_q    <= 1'b0;
      oc_q    <= '0;
      oi_q    <= '0;
      ol_q    <= 1'b0;
      for (int i = 0; i < 64; i++) qt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      ov_q    <= ov_d;
      oc_q    <= oc_d;
      oi_q    <= oi_d;
      ol_q    <= ol_d;
      if (qt_wr_en && state_q == StIdle) qt_q[qt_wr_addr] <= qt_wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      for (int k = 0; k < 64; k++) blk_q[k] <= coef_in[k*CW +: CW];
    end
  end

endmodule
